// File: rtl/gosterge_pkg.sv
// Shared 7-segment glyph constants, display-buffer record and BCD-to-segment
// decoder used by the display scanner and by the LED/UART debug path.
package gosterge_pkg;

  localparam logic [6:0] SEG_BOS   = 7'h7F;
  localparam logic [6:0] SEG_TIRE  = 7'b0111111;
  localparam logic [3:0] AN_KAPALI = 4'b1111;

  // One complete frame's worth of display content.
  typedef struct packed {
    logic [15:0] rakamlar;
    logic [3:0]  dp_maske;
    logic [3:0]  blink_maske;
    logic        lz_bos;
  } gosterge_t;

  // Segments are {g,f,e,d,c,b,a}, active-low; non-BCD codes render as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_TIRE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
module bcd_7seg
  import gosterge_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/gosterge_tarayici.sv
// Double-buffered 4-digit common-anode 7-segment scanner with leading-zero
// blanking, per-digit blink and one dead cycle at the start of every slot.
module gosterge_tarayici
  import gosterge_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 4000,
  parameter int BLINK_HZ = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        yukle,
  input  logic [15:0] rakamlar,
  input  logic [3:0]  dp_maske,
  input  logic [3:0]  blink_maske,
  input  logic        lz_bos,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        cerceve_bitti
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W     = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLK_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic [BLK_W-1:0] blink_cnt;
  logic [1:0]       idx;
  logic             faz;
  gosterge_t        bekleyen;
  gosterge_t        aktif;
  gosterge_t        yeni;

  logic       slot_sonu;
  logic       sarma;
  logic [3:0] sifir;
  logic [3:0] bos;
  logic [3:0] cur_bcd;
  logic [6:0] cur_glyph;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign yeni      = '{rakamlar: rakamlar, dp_maske: dp_maske,
                       blink_maske: blink_maske, lz_bos: lz_bos};
  assign slot_sonu = (pre == PRE_W'(SCAN_DIV - 1));
  assign sarma     = slot_sonu && (idx == 2'd3);
  assign cur_bcd   = aktif.rakamlar[idx*4 +: 4];

  bcd_7seg u_bcd_7seg (
    .bcd (cur_bcd),
    .seg (cur_glyph)
  );

  // A digit is blanked only when it and every digit to its left are zero.
  always_comb begin
    for (int i = 0; i < 4; i++) sifir[i] = (aktif.rakamlar[i*4 +: 4] == 4'd0);
    bos[3] = aktif.lz_bos & sifir[3];
    bos[2] = bos[3] & sifir[2];
    bos[1] = bos[2] & sifir[1];
    bos[0] = 1'b0;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    an_d  = AN_KAPALI;
    seg_d = SEG_BOS;
    dp_d  = 1'b1;
    if (pre != '0 && !(aktif.blink_maske[idx] && faz)) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = bos[idx] ? SEG_BOS : cur_glyph;
      dp_d  = ~aktif.dp_maske[idx];
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      pre           <= '0;
      idx           <= 2'd0;
      blink_cnt     <= '0;
      faz           <= 1'b0;
      bekleyen      <= '0;
      aktif         <= '0;
      an            <= AN_KAPALI;
      seg           <= SEG_BOS;
      dp            <= 1'b1;
      cerceve_bitti <= 1'b0;
    end else begin
      if (slot_sonu) begin
        pre <= '0;
        idx <= idx + 2'd1;
      end else begin
        pre <= pre + PRE_W'(1);
      end

      if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        faz       <= ~faz;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end

      if (yukle) bekleyen <= yeni;
      // A strobe landing on the frame boundary skips the pending stage.
      if (sarma) aktif <= yukle ? yeni : bekleyen;

      an            <= an_d;
      seg           <= seg_d;
      dp            <= dp_d;
      cerceve_bitti <= sarma;
    end
  end

endmodule

// File: tb/tb_gosterge_tarayici.sv
// Directed bench for gosterge_tarayici: a cycle model pushes expected pin
// values into a scoreboard queue before each edge; they are popped after it.
module tb_gosterge_tarayici;

  localparam int CLK_HZ    = 40;
  localparam int SCAN_HZ   = 10;
  localparam int BLINK_HZ  = 1;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 20;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        yukle = 1'b0;
  logic [15:0] rakamlar = '0;
  logic [3:0]  dp_maske = '0;
  logic [3:0]  blink_maske = '0;
  logic        lz_bos = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        cerceve_bitti;

  gosterge_tarayici #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .yukle         (yukle),
    .rakamlar      (rakamlar),
    .dp_maske      (dp_maske),
    .blink_maske   (blink_maske),
    .lz_bos        (lz_bos),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .cerceve_bitti (cerceve_bitti)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       cb;
  } beklenen_t;

  beklenen_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cb_count = 0;

  logic [6:0] glyph [16];
  int          m_pre, m_idx, m_bcnt;
  logic        m_faz;
  logic [15:0] p_rak, a_rak;
  logic [3:0]  p_dp, a_dp, p_blk, a_blk;
  logic        p_lz, a_lz;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] digit_of(input logic [15:0] r, input int i);
    return 4'((r >> (4 * i)) & 16'hF);
  endfunction

  // Compute expected pins for this edge, advance the model, clock, then compare.
  task automatic step();
    beklenen_t e, g;
    logic wrap, blanked;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, cb: 1'b0};
    if (!reset) begin
      m_pre = 0; m_idx = 0; m_bcnt = 0; m_faz = 1'b0;
      p_rak = '0; p_dp = '0; p_blk = '0; p_lz = 1'b0;
      a_rak = '0; a_dp = '0; a_blk = '0; a_lz = 1'b0;
    end else begin
      wrap = (m_pre == SCAN_DIV - 1) && (m_idx == 3);
      e.cb = wrap;
      if (m_pre != 0 && !(a_blk[m_idx] && m_faz)) begin
        blanked = a_lz && (m_idx > 0);
        for (int j = m_idx; j < 4; j++) if (digit_of(a_rak, j) != 4'd0) blanked = 1'b0;
        e.an  = 4'hF;
        e.an[m_idx] = 1'b0;
        e.seg = blanked ? 7'h7F : glyph[digit_of(a_rak, m_idx)];
        e.dp  = ~a_dp[m_idx];
      end
      if (wrap) begin
        a_rak = yukle ? rakamlar : p_rak;
        a_dp  = yukle ? dp_maske : p_dp;
        a_blk = yukle ? blink_maske : p_blk;
        a_lz  = yukle ? lz_bos : p_lz;
      end
      if (yukle) begin
        p_rak = rakamlar; p_dp = dp_maske; p_blk = blink_maske; p_lz = lz_bos;
      end
      if (m_pre == SCAN_DIV - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end else m_pre++;
      if (m_bcnt == BLINK_DIV - 1) begin
        m_bcnt = 0;
        m_faz  = ~m_faz;
      end else m_bcnt++;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    check("an", 16'(an), 16'(g.an));
    check("seg", 16'(seg), 16'(g.seg));
    check("dp", 16'(dp), 16'(g.dp));
    check("cerceve_bitti", 16'(cerceve_bitti), 16'(g.cb));
    if (cerceve_bitti) cb_count++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model sits in the given slot cycle (bounded to one frame).
  task automatic go_to(input int idx, input int pre);
    for (int i = 0; i < 4 * SCAN_DIV && !(m_idx == idx && m_pre == pre); i++) step();
    check("sync", 16'(m_idx * 16 + m_pre), 16'(idx * 16 + pre));
  endtask

  task automatic load(input logic [15:0] r, input logic [3:0] d,
                      input logic [3:0] b, input logic lz);
    rakamlar = r; dp_maske = d; blink_maske = b; lz_bos = lz; yukle = 1'b1;
    step();
    yukle = 1'b0;
    rakamlar = $urandom; dp_maske = 4'($urandom); blink_maske = 4'($urandom);
    lz_bos = 1'($urandom);
  endtask

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
              7'b0111111};

    // Reset with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      yukle = 1'($urandom); rakamlar = $urandom; dp_maske = 4'($urandom);
      blink_maske = 4'($urandom); lz_bos = 1'($urandom);
      step();
    end
    check("rst_an", 16'(an), 16'h000F);
    check("rst_seg", 16'(seg), 16'h007F);
    check("rst_dp", 16'(dp), 16'h0001);
    check("rst_cb", 16'(cerceve_bitti), 16'h0000);

    // Release: one dead cycle, then digit 0 showing a cleared zero.
    reset = 1'b1; yukle = 1'b0;
    step();
    check("rel_dead_an", 16'(an), 16'h000F);
    step();
    check("rel_an", 16'(an), 16'h000E);
    check("rel_seg", 16'(seg), 16'h0040);

    // Mid-frame load: old content persists until the boundary.
    go_to(1, 2);
    load(16'h1234, 4'b0100, 4'b0000, 1'b0);
    run(40);

    // cerceve_bitti period is one frame.
    cb_count = 0;
    run(64);
    check("cb_per_64", 16'(cb_count), 16'd4);

    // Strobe on the wrap cycle is applied to the frame starting now.
    go_to(3, SCAN_DIV - 1);
    load(16'h0909, 4'b0000, 4'b0000, 1'b0);
    step();
    check("bypass_dead", 16'(an), 16'h000F);
    step();
    check("bypass_seg", 16'(seg), 16'h0010);
    run(16);

    // Leading-zero blanking.
    load(16'h0007, 4'b0000, 4'b0000, 1'b1);
    run(40);
    load(16'h0000, 4'b0010, 4'b0000, 1'b1);
    run(40);
    load(16'h0000, 4'b0000, 4'b0000, 1'b0);
    run(40);

    // Blink on digit 0 plus an invalid code on digit 1.
    load(16'h00A5, 4'b0000, 4'b0001, 1'b0);
    run(100);

    // Mid-frame reset, then restart at index 0 with cleared buffers.
    go_to(2, 2);
    reset = 1'b0;
    step();
    check("mrst_an", 16'(an), 16'h000F);
    check("mrst_seg", 16'(seg), 16'h007F);
    reset = 1'b1;
    step();
    step();
    check("mrst_an0", 16'(an), 16'h000E);
    check("mrst_seg0", 16'(seg), 16'h0040);
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gosterge_tarayici.md
# gosterge_tarayici

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display, sitting directly downstream of the clock/calendar update logic in `saat_guncelleme`. It takes four BCD digits plus per-digit decimal-point and blink masks, double-buffers them so a frame is never torn, and scans the digits with leading-zero blanking and anti-ghosting dead time. All outputs are registered and active-low.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency
- `SCAN_HZ`, 4000, digit-slot rate; `SCAN_DIV = CLK_HZ/SCAN_HZ` cycles per digit slot, must be ≥ 2
- `BLINK_HZ`, 2, blink rate; phase toggles every `BLINK_DIV = CLK_HZ/(2*BLINK_HZ)` cycles
- `CLK` input 1: single system clock; all logic on rising edge
- `reset` input 1: synchronous, active-low
- `yukle` input 1: one-cycle strobe that captures `rakamlar`, `dp_maske`, `blink_maske` and `lz_bos` into the pending buffer
- `rakamlar` input 16: BCD digits; `[3:0]` is digit 0 (rightmost, `an[0]`), `[15:12]` is digit 3
- `dp_maske` input 4: bit i lights the decimal point of digit i
- `blink_maske` input 4: bit i makes digit i blink
- `lz_bos` input 1: enable leading-zero blanking
- `an` output 4: anode enables, active-low
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low
- `dp` output 1: decimal point, active-low
- `cerceve_bitti` output 1: one-cycle pulse when digit 3's slot ends

## Operation
- Registers: pending buffer, active buffer, prescaler `0..SCAN_DIV-1`, digit index `0..3`, blink counter `0..BLINK_DIV-1`, blink phase bit.
- `yukle` writes the pending buffer. The active buffer copies pending at the frame boundary, which is the cycle the index wraps 3→0.
- If `yukle` coincides with the boundary, the strobed inputs go straight to the active buffer (bypass) and to pending.
- Prescaler counts every cycle. At `SCAN_DIV-1` it resets to 0 and the index increments mod 4. The index is 0 after reset.
- Per slot:
  - Cycle 0 of each slot is dead time: `an=4'b1111`, `seg=7'h7F`, `dp=1`.
  - Remaining cycles drive `an` with a single 0 at the index position.
- Glyphs: 0..9 use the standard encoding (0=`7'b1000000`, 1=`7'b1111001`, 8=`7'b0000000`). Codes 10..15 show `-` (`7'b0111111`).
- Leading-zero blanking (`lz_bos=1`):
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode active but drives `seg=7'h7F`. `dp` still follows `dp_maske`.
- Blink: when `blink_maske[i]=1` and blink phase is 1, digit i's slot behaves as dead time for the whole slot (`an=4'b1111`, `dp=1`). Phase starts at 0 and toggles when the blink counter wraps.
- `cerceve_bitti` pulses in the cycle the index wraps 3→0.
- Reset (`reset=0` on a clock edge), including mid-frame:
  - All counters, the phase, and both buffers go to 0.
  - Outputs: `an=4'b1111`, `seg=7'h7F`, `dp=1`, `cerceve_bitti=0`.

## Timing
- Outputs are registered, so the slot/index state at cycle n appears on pins at n+1.
- First cycle after reset release: the output register samples dead time. Digit 0 is visible (`an=4'b1110`) from the second edge after release.
- Strobe latency: `yukle` at cycle t becomes visible at the first frame boundary at or after t, plus 1 register cycle. Worst case is 4·`SCAN_DIV`+1 cycles.
- Full frame is 4·`SCAN_DIV` cycles. `cerceve_bitti` period equals the frame length exactly.
- No backpressure. Multiple `yukle` pulses within one frame: the last one wins.

## Structure
- Shared package `gosterge_pkg` holds:
  - glyph constants (`SEG_BOS=7'h7F`, `SEG_TIRE=7'b0111111`)
  - the BCD-to-segment function
  - the anode-off constant `AN_KAPALI=4'b1111`
- One sub-module `bcd_7seg` (combinational, 4→7) wraps the package function for reuse by the LED/UART debug path.
- The prescaler and blink counter are inline counters, not separate modules.

## Test plan
Bench parameters: `CLK_HZ=40`, `SCAN_HZ=10` (`SCAN_DIV=4`), `BLINK_HZ=1` (`BLINK_DIV=20`).
- Reset: hold `reset=0` for 3 cycles with random inputs -> `an=1111`, `seg=7F`, `dp=1`, `cerceve_bitti=0`. Release -> one dead cycle, then `an=1110`, `seg=7'b1000000`.
- Scan/load: `yukle` with `rakamlar=16'h1234`, `dp_maske=4'b0100` mid-frame -> old value persists to the boundary. The next frame shows slots 4,3,2,1 on `an` 1110/1101/1011/0111, with `dp=0` only in slot 2. One dead cycle starts each slot, and `cerceve_bitti` pulses every 16 cycles.
- Boundary bypass: `yukle` (`16'h0909`) exactly in the wrap cycle -> applied in the frame that starts immediately.
- Leading zeros: `16'h0007`, `lz_bos=1` -> digits 3..1 show `seg=7F` with their anodes active, digit 0 shows 7. `16'h0000` -> only digit 0 shows 0. With `lz_bos=0` all digits show 0.
- Blink/invalid: `blink_maske=4'b0001`, `rakamlar=16'h00A5` -> digit 0's anode stays high for 20 cycles, then is active for 20, alternating. Digit 1 always shows `0111111`.
- Mid-frame reset: assert `reset` during slot 2 -> outputs off next edge. After release, scan restarts at index 0 with cleared buffers.
